instruction_issuer: RTL and testbench
=====================================

// Module: instruction_issuer
// PURPOSE
//  Global program sequencer driving the broadcast instruction bus consumed by every cell_core in the grid.
//  Fetches 16-bit instructions from program memory and issues one per 2 cycles with an execution_enable strobe.
//  Resolves JMP/CALL/RET/BRZ/JOIN/HALT itself, using grid-reduced divergence flags.
//  Maintains the shared 32-entry call/reconvergence stack and broadcasts PC/SP so cells track their active path.
// PARAMETERS
//  START_ADDR   12'h000  PC loaded on start
//  STACK_DEPTH  32       stack entries; must equal 2**5 (SP width fixed at 5)
// PORTS
//  clk                   in   1   clock
//  rst_n                 in   1   asynchronous active-low reset
//  start                 in   1   pulse: begin program at START_ADDR (honoured in IDLE/HALTED only)
//  pm_en                 out  1   program-memory read enable
//  pm_addr               out  12  program-memory address
//  pm_data               in   16  read data, valid 1 cycle after pm_en
//  instruction           out  16  broadcast instruction (registered)
//  next_program_counter  out  12  resolved PC after current instruction
//  next_stack_pointer    out  5   resolved SP after current instruction
//  execution_enable      out  1   1-cycle strobe: instruction valid, cells execute
//  diverge_any           in   1   OR of all cell diverge outputs (combinational, same cycle)
//  diverge_all           in   1   AND of all cell diverge outputs (combinational, same cycle)
//  busy                  out  1   program running
//  halted                out  1   HALT reached
//  error                 out  1   sticky: stack overflow or RET underflow
// BEHAVIOUR
//  Reset: state IDLE; every output 0; pc=0, sp=0, error=0; stack contents don't-care.
//  FSM: IDLE -start-> FETCH. FETCH -> ISSUE. ISSUE -> FETCH, HALTED (HALT), or ERROR.
//       HALTED -start-> FETCH (pc=START_ADDR, sp=0, halted cleared). ERROR is terminal until reset.
//  FETCH: pm_en=1, pm_addr=pc. ISSUE: instruction<=pm_data latched, execution_enable=1 for exactly one cycle.
//  Opcodes come from isa.sv; all non-control opcodes mean pc<=pc+1, sp unchanged.
//   JMP  imm12=instr[11:0]: pc<=imm12.
//   CALL: push {JOIN=0, pc+1}; pc<=imm12.
//   RET:  pop entry; pc<=entry.addr. If sp==0: error=1 -> ERROR.
//   BRZ  addr=instr[7:0] zero-extended; cells report diverge=1 when the branch is taken:
//     diverge_all=1 -> pc<=addr; diverge_any=0 -> pc<=pc+1;
//     mixed -> push {JOIN=1, addr}; pc<=pc+1 (fall-through path first; taken cells mask themselves via SP).
//   JOIN: if sp>0 and top.JOIN=1, pop and pc<=top.addr; otherwise pc<=pc+1.
//   HALT: halted<=1, busy<=0; pc frozen.
//  diverge_any/all are sampled only in the ISSUE cycle of a BRZ and ignored otherwise.
//  next_program_counter/next_stack_pointer update in the cycle after the ISSUE cycle.
//  They hold until the next ISSUE resolves.
//  pc arithmetic is modulo 4096 (12'hFFF+1 wraps to 0, no flag).
//  Push with sp==STACK_DEPTH-1 (full): error=1, no write, -> ERROR.
//  busy=1 in FETCH/ISSUE. start during FETCH/ISSUE is ignored.
//  rst_n assertion at any point aborts immediately to reset values, with no partial push/pop visible.
// STRUCTURE
//  isa.sv: opcode macros `OP_JMP,`OP_CALL,`OP_RET,`OP_BRZ,`OP_JOIN,`OP_HALT; stack entry typedef {join,addr[11:0]}.
//  Sub-module issuer_stack: 32x13 register file with push/pop/top, full/empty flags, and 5-bit sp.
//   Push and pop in the same cycle are illegal (the FSM never issues both).
//  Top level holds the FSM, pc/instruction registers, and next-PC mux.
// TESTING
//  1 start, program {ALU op @0, ALU op @1, HALT @2} -> 3 execution_enable pulses 2 cycles apart; halted=1; next_program_counter=2.
//  2 JMP 12'h010 @0 -> pm_addr=12'h010 on the next FETCH; CALL 12'h020 @0x10, RET @0x20 -> sp 0->1->0, fetch resumes at 0x11.
//  3 BRZ addr 0x40 @5:
//      diverge_all=1 -> pc 0x40.
//      diverge_any=0 -> pc 6.
//      mixed -> pc 6, sp=1, JOIN at 7 pops -> pc 0x40, sp=0.
//  4 33 nested CALLs -> error=1 on the 32nd push, state ERROR, no further pm_en; RET with sp=0 -> error=1.
//  5 rst_n low mid-ISSUE of a CALL -> all outputs 0 asynchronously, sp=0; start after release runs from START_ADDR.
//  6 pc=12'hFFF with ALU op -> next fetch at 12'h000; start pulses while busy have no effect.

Source files
------------

// File: rtl/instruction_issuer_pkg.sv
// Shared types and ISA encodings for the broadcast instruction issuer.
// Opcode lives in instr[15:12]; any value not listed here is a non-control (ALU) op.
package instruction_issuer_pkg;

  localparam int ADDR_W = 12;
  localparam int SP_W   = 5;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_JOIN = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic              isJoin;
    logic [ADDR_W-1:0] addr;
  } stack_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED,
    S_ERROR
  } state_e;

  function automatic logic [3:0] opcodeOf(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/issuer_stack.sv
// Shared call/reconvergence stack: 32x13 register file with a 5-bit stack pointer.
// The top entry sits at sp-1; the last slot is never written, so sp saturates at DEPTH-1.
module issuer_stack
  import instruction_issuer_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [12:0]     i_pushEntry,
  output logic [12:0]     o_top,
  output logic [SP_W-1:0] o_sp,
  output logic            o_full,
  output logic            o_empty
);

  logic [12:0]     r_mem [DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_topIdx;

  assign w_topIdx = r_sp - 5'd1;
  assign o_top    = r_mem[w_topIdx];
  assign o_sp     = r_sp;
  assign o_full   = (r_sp == SP_W'(DEPTH - 1));
  assign o_empty  = (r_sp == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (i_clear) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 5'd1;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - 5'd1;
    end
  end

  // Contents need no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (i_push && !o_full && !i_clear) begin
      r_mem[r_sp] <= i_pushEntry;
    end
  end

endmodule

// File: rtl/instruction_issuer.sv
// Global program sequencer: fetches, resolves control flow with grid-reduced divergence,
// and broadcasts one instruction every two cycles together with the resolved PC/SP.
module instruction_issuer
  import instruction_issuer_pkg::*;
#(
  parameter logic [11:0] START_ADDR  = 12'h000,
  parameter int          STACK_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_pm_en,
  output logic [11:0] o_pm_addr,
  input  logic [15:0] i_pm_data,
  output logic [15:0] o_instruction,
  output logic [11:0] o_next_program_counter,
  output logic [4:0]  o_next_stack_pointer,
  output logic        o_execution_enable,
  input  logic        i_diverge_any,
  input  logic        i_diverge_all,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_error
);

  state_e       r_state;
  state_e       w_nextState;
  logic [11:0]  r_pc;
  logic [15:0]  r_instruction;
  logic         r_execEn;
  logic [11:0]  r_nextPc;
  logic [4:0]   r_nextSp;
  logic         r_error;

  logic         w_startAccept;
  logic [3:0]   w_opcode;
  logic [11:0]  w_imm12;
  logic [11:0]  w_brAddr;
  logic [11:0]  w_pcInc;
  logic [11:0]  w_pcResolved;
  logic [4:0]   w_spResolved;
  logic         w_push;
  logic         w_pop;
  logic         w_errSet;
  stack_entry_t w_pushEntry;
  stack_entry_t w_top;
  logic [12:0]  w_stackTop;
  logic [4:0]   w_sp;
  logic         w_full;
  logic         w_empty;

  assign w_startAccept = i_start && (r_state == S_IDLE || r_state == S_HALTED);
  assign w_opcode      = opcodeOf(i_pm_data);
  assign w_imm12       = i_pm_data[11:0];
  assign w_brAddr      = {4'h0, i_pm_data[7:0]};
  assign w_pcInc       = r_pc + 12'd1;
  assign w_top         = stack_entry_t'(w_stackTop);

  issuer_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_clear    (w_startAccept),
    .i_pushEntry(w_pushEntry),
    .o_top      (w_stackTop),
    .o_sp       (w_sp),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Control flow is resolved from pm_data while it is still on the bus in ISSUE.
  always_comb begin
    w_nextState  = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_pushEntry  = '0;
    w_pcResolved = w_pcInc;
    w_spResolved = w_sp;
    w_errSet     = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (i_start) w_nextState = S_FETCH;
      end
      S_FETCH: w_nextState = S_ISSUE;
      S_ISSUE: begin
        case (w_opcode)
          OP_JMP: w_pcResolved = w_imm12;
          OP_CALL: begin
            if (w_full) begin
              w_errSet = 1'b1;
            end else begin
              w_push             = 1'b1;
              w_pushEntry.isJoin = 1'b0;
              w_pushEntry.addr   = w_pcInc;
              w_pcResolved       = w_imm12;
              w_spResolved       = w_sp + 5'd1;
            end
          end
          OP_RET: begin
            if (w_empty) begin
              w_errSet = 1'b1;
            end else begin
              w_pop        = 1'b1;
              w_pcResolved = w_top.addr;
              w_spResolved = w_sp - 5'd1;
            end
          end
          OP_BRZ: begin
            if (i_diverge_all) begin
              w_pcResolved = w_brAddr;
            end else if (i_diverge_any) begin
              // Mixed: fall-through runs first, taken path is parked for JOIN.
              if (w_full) begin
                w_errSet = 1'b1;
              end else begin
                w_push             = 1'b1;
                w_pushEntry.isJoin = 1'b1;
                w_pushEntry.addr   = w_brAddr;
                w_spResolved       = w_sp + 5'd1;
              end
            end
          end
          OP_JOIN: begin
            if (!w_empty && w_top.isJoin) begin
              w_pop        = 1'b1;
              w_pcResolved = w_top.addr;
              w_spResolved = w_sp - 5'd1;
            end
          end
          OP_HALT: w_pcResolved = r_pc;
          default: ;
        endcase
        if (w_errSet) begin
          w_nextState = S_ERROR;
        end else if (w_opcode == OP_HALT) begin
          w_nextState = S_HALTED;
        end else begin
          w_nextState = S_FETCH;
        end
      end
      S_ERROR: ;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Broadcast registers change only when an instruction resolves without error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_execEn      <= 1'b0;
      r_nextPc      <= '0;
      r_nextSp      <= '0;
      r_error       <= 1'b0;
    end else begin
      r_execEn <= 1'b0;
      if (w_startAccept) begin
        r_pc <= START_ADDR;
      end else if (r_state == S_ISSUE && !w_errSet) begin
        r_pc          <= w_pcResolved;
        r_instruction <= i_pm_data;
        r_execEn      <= 1'b1;
        r_nextPc      <= w_pcResolved;
        r_nextSp      <= w_spResolved;
      end
      if (w_errSet) r_error <= 1'b1;
    end
  end

  assign o_pm_en                = (r_state == S_FETCH);
  assign o_pm_addr              = o_pm_en ? r_pc : 12'h000;
  assign o_instruction          = r_instruction;
  assign o_next_program_counter = r_nextPc;
  assign o_next_stack_pointer   = r_nextSp;
  assign o_execution_enable     = r_execEn;
  assign o_busy                 = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign o_halted               = (r_state == S_HALTED);
  assign o_error                = r_error;

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench for instruction_issuer: expected issues and fetch addresses are queued
// per program, and monitors pop/compare them whenever the DUT strobes.
module tb_instruction_issuer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pmEn;
  logic [11:0] pmAddr;
  logic [15:0] pmData;
  logic [15:0] instruction;
  logic [11:0] nextPc;
  logic [4:0]  nextSp;
  logic        execEn;
  logic        divAny;
  logic        divAll;
  logic        busy;
  logic        halted;
  logic        errorOut;

  typedef struct {
    logic [15:0] instr;
    logic [11:0] pc;
    logic [4:0]  sp;
  } issue_t;

  issue_t      expIssues[$];
  logic [11:0] expFetches[$];
  logic [15:0] progMem [4096];
  int          checkCount = 0;
  int          passCount  = 0;
  int          cycleCount = 0;

  instruction_issuer #(
    .START_ADDR (12'h000),
    .STACK_DEPTH(32)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_start               (start),
    .o_pm_en               (pmEn),
    .o_pm_addr             (pmAddr),
    .i_pm_data             (pmData),
    .o_instruction         (instruction),
    .o_next_program_counter(nextPc),
    .o_next_stack_pointer  (nextSp),
    .o_execution_enable    (execEn),
    .i_diverge_any         (divAny),
    .i_diverge_all         (divAll),
    .o_busy                (busy),
    .o_halted              (halted),
    .o_error               (errorOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Synchronous program memory: data valid the cycle after pm_en.
  always @(posedge clk) begin
    if (pmEn) pmData <= progMem[pmAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic expectIssue(input logic [15:0] instr, input logic [11:0] pc, input logic [4:0] sp);
    issue_t e;
    e.instr = instr;
    e.pc    = pc;
    e.sp    = sp;
    expIssues.push_back(e);
  endtask

  task automatic expectFetch(input logic [11:0] addr);
    expFetches.push_back(addr);
  endtask

  task automatic monitorIssues();
    issue_t e;
    int     lastCycle;
    bit     lastValid;
    lastValid = 1'b0;
    lastCycle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lastValid = 1'b0;
      end else if (execEn) begin
        if (lastValid) checkOutput("issueGap", 32'(cycleCount - lastCycle), 32'd2);
        lastValid = 1'b1;
        lastCycle = cycleCount;
        if (expIssues.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedIssue: got instr 0x%0h, expected no issue", instruction);
        end else begin
          e = expIssues.pop_front();
          checkOutput("issueInstr", 32'(instruction), 32'(e.instr));
          checkOutput("issueNextPc", 32'(nextPc), 32'(e.pc));
          checkOutput("issueNextSp", 32'(nextSp), 32'(e.sp));
        end
      end
    end
  endtask

  task automatic monitorFetches();
    logic [11:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && pmEn) begin
        if (expFetches.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedFetch: got pm_addr 0x%0h, expected no fetch", pmAddr);
        end else begin
          a = expFetches.pop_front();
          checkOutput("fetchAddr", 32'(pmAddr), 32'(a));
        end
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetInstr", 32'(instruction), 32'd0);
    checkOutput("resetPcSp", 32'({nextPc, nextSp}), 32'd0);
    checkOutput("resetCtrl", 32'({pmEn, pmAddr, execEn, busy, halted, errorOut}), 32'd0);
    for (int a = 0; a < 4096; a++) progMem[a] = 16'hF000;
    rst_n = 1'b1;
  endtask

  // Pulses start, waits for HALTED/ERROR within a bound, then confirms the queues drained.
  task automatic applyStimulus(input int maxCycles, input bit pokeStart);
    bit done;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done = 1'b0;
    for (int n = 0; n < maxCycles && !done; n++) begin
      if (halted || errorOut) begin
        done = 1'b1;
      end else begin
        start = pokeStart && (n % 3 == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!done) begin
      checkCount++;
      $display("[TB] FAIL runTimeout: still running after %0d cycles, expected halted or error", maxCycles);
    end
    repeat (3) @(negedge clk);
    checkOutput("issuesLeft", 32'(expIssues.size()), 32'd0);
    checkOutput("fetchesLeft", 32'(expFetches.size()), 32'd0);
  endtask

  task automatic loadBrzProgram();
    progMem[0]     = 16'h8005;
    progMem[5]     = 16'hB040;
    progMem[6]     = 16'h3000;
    progMem[7]     = 16'hC000;
    progMem[8]     = 16'hF000;
    progMem[12'h40] = 16'hF000;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    divAny = 1'b0;
    divAll = 1'b0;
    fork
      monitorIssues();
      monitorFetches();
    join_none

    // Straight-line program ending in HALT.
    doReset();
    progMem[0] = 16'h1001;
    progMem[1] = 16'h2002;
    progMem[2] = 16'hF000;
    expectFetch(12'h000); expectFetch(12'h001); expectFetch(12'h002);
    expectIssue(16'h1001, 12'h001, 5'd0);
    expectIssue(16'h2002, 12'h002, 5'd0);
    expectIssue(16'hF000, 12'h002, 5'd0);
    applyStimulus(50, 1'b0);
    checkOutput("t1Halted", 32'(halted), 32'd1);
    checkOutput("t1Busy", 32'(busy), 32'd0);
    checkOutput("t1NextPc", 32'(nextPc), 32'h002);
    checkOutput("t1Error", 32'(errorOut), 32'd0);

    // JMP, CALL, RET.
    doReset();
    progMem[0]      = 16'h8010;
    progMem[12'h10] = 16'h9020;
    progMem[12'h20] = 16'hA000;
    expectFetch(12'h000); expectFetch(12'h010); expectFetch(12'h020); expectFetch(12'h011);
    expectIssue(16'h8010, 12'h010, 5'd0);
    expectIssue(16'h9020, 12'h020, 5'd1);
    expectIssue(16'hA000, 12'h011, 5'd0);
    expectIssue(16'hF000, 12'h011, 5'd0);
    applyStimulus(50, 1'b0);

    // BRZ with all cells diverging.
    doReset();
    loadBrzProgram();
    divAll = 1'b1; divAny = 1'b1;
    expectFetch(12'h000); expectFetch(12'h005); expectFetch(12'h040);
    expectIssue(16'h8005, 12'h005, 5'd0);
    expectIssue(16'hB040, 12'h040, 5'd0);
    expectIssue(16'hF000, 12'h040, 5'd0);
    applyStimulus(50, 1'b0);

    // BRZ with no cell diverging; JOIN on an empty stack falls through.
    doReset();
    loadBrzProgram();
    divAll = 1'b0; divAny = 1'b0;
    expectFetch(12'h000); expectFetch(12'h005); expectFetch(12'h006);
    expectFetch(12'h007); expectFetch(12'h008);
    expectIssue(16'h8005, 12'h005, 5'd0);
    expectIssue(16'hB040, 12'h006, 5'd0);
    expectIssue(16'h3000, 12'h007, 5'd0);
    expectIssue(16'hC000, 12'h008, 5'd0);
    expectIssue(16'hF000, 12'h008, 5'd0);
    applyStimulus(50, 1'b0);

    // BRZ mixed: fall-through first, JOIN reconverges to the taken path.
    doReset();
    loadBrzProgram();
    divAll = 1'b0; divAny = 1'b1;
    expectFetch(12'h000); expectFetch(12'h005); expectFetch(12'h006);
    expectFetch(12'h007); expectFetch(12'h040);
    expectIssue(16'h8005, 12'h005, 5'd0);
    expectIssue(16'hB040, 12'h006, 5'd1);
    expectIssue(16'h3000, 12'h007, 5'd1);
    expectIssue(16'hC000, 12'h040, 5'd0);
    expectIssue(16'hF000, 12'h040, 5'd0);
    applyStimulus(50, 1'b0);

    // Nested CALLs overflow on the 32nd push.
    doReset();
    divAll = 1'b0; divAny = 1'b0;
    for (int i = 0; i < 33; i++) progMem[i] = 16'h9000 | 16'(i + 1);
    for (int i = 0; i < 32; i++) expectFetch(12'(i));
    for (int i = 0; i < 31; i++) expectIssue(16'h9000 | 16'(i + 1), 12'(i + 1), 5'(i + 1));
    applyStimulus(200, 1'b0);
    checkOutput("t4Error", 32'(errorOut), 32'd1);
    checkOutput("t4Halted", 32'(halted), 32'd0);
    checkOutput("t4Busy", 32'(busy), 32'd0);
    checkOutput("t4NextSp", 32'(nextSp), 32'd31);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t4ErrorSticky", 32'({errorOut, busy}), 32'b10);

    // RET on an empty stack.
    doReset();
    progMem[0] = 16'hA000;
    expectFetch(12'h000);
    applyStimulus(20, 1'b0);
    checkOutput("t4RetUnderflow", 32'(errorOut), 32'd1);

    // Asynchronous reset in the middle of a CALL's ISSUE cycle.
    doReset();
    progMem[0]      = 16'h9020;
    progMem[12'h20] = 16'hF000;
    expectFetch(12'h000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checkOutput("t5InIssue", 32'({busy, pmEn}), 32'b10);
    rst_n = 1'b0;
    #1;
    checkOutput("t5AbortCtrl", 32'({pmEn, pmAddr, execEn, busy, halted, errorOut}), 32'd0);
    checkOutput("t5AbortPcSp", 32'({nextPc, nextSp}), 32'd0);
    checkOutput("t5AbortInstr", 32'(instruction), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expectFetch(12'h000); expectFetch(12'h020);
    expectIssue(16'h9020, 12'h020, 5'd1);
    expectIssue(16'hF000, 12'h020, 5'd1);
    applyStimulus(50, 1'b0);

    // PC wrap at 12'hFFF, with start pulses while busy.
    doReset();
    divAll = 1'b0; divAny = 1'b1;
    progMem[0]       = 16'hC000;
    progMem[1]       = 16'hB050;
    progMem[2]       = 16'h8FFF;
    progMem[12'hFFF] = 16'h4000;
    expectFetch(12'h000); expectFetch(12'h001); expectFetch(12'h002);
    expectFetch(12'hFFF); expectFetch(12'h000); expectFetch(12'h050);
    expectIssue(16'hC000, 12'h001, 5'd0);
    expectIssue(16'hB050, 12'h002, 5'd1);
    expectIssue(16'h8FFF, 12'hFFF, 5'd1);
    expectIssue(16'h4000, 12'h000, 5'd1);
    expectIssue(16'hC000, 12'h050, 5'd0);
    expectIssue(16'hF000, 12'h050, 5'd0);
    applyStimulus(100, 1'b1);
    checkOutput("t6Halted", 32'(halted), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
